// File: rtl/auth_game_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : auth_game_ctrl_if
// Brief    : Handshake bundle between the keypad/game side and auth_game_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface auth_game_ctrl_if #(
    parameter int DIGIT_W = 4,
    parameter int USER_W  = 1
);
    logic               Password_Enter;
    logic [DIGIT_W-1:0] Password;
    logic [USER_W-1:0]  User_Sel;
    logic               Logout;
    logic               Load_P1_In;
    logic               RNG_Gen_In;
    logic               DigitTime_Out;
    logic               Logged_In;
    logic               Logged_Out;
    logic               Auth_Fail;
    logic               Locked;
    logic               Load_P1_Out;
    logic               RNG_Gen_Out;
    logic               Timer_enable;
    logic               Timer_reconfig;

    modport master (
        output Password_Enter, Password, User_Sel, Logout,
               Load_P1_In, RNG_Gen_In, DigitTime_Out,
        input  Logged_In, Logged_Out, Auth_Fail, Locked,
               Load_P1_Out, RNG_Gen_Out, Timer_enable, Timer_reconfig
    );

    modport slave (
        input  Password_Enter, Password, User_Sel, Logout,
               Load_P1_In, RNG_Gen_In, DigitTime_Out,
        output Logged_In, Logged_Out, Auth_Fail, Locked,
               Load_P1_Out, RNG_Gen_Out, Timer_enable, Timer_reconfig
    );
endinterface
`default_nettype wire

// File: rtl/auth_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : auth_game_ctrl
// Brief    : Multi-user streaming password check gating player-load/RNG and
//            the digit timer. Define AUTH_LOCKOUT_EN for failed-attempt lockout.
// Revision : 1.0 - initial release
// ============================================================================
module auth_game_ctrl #(
    parameter int DIGIT_W     = 4,
    parameter int N_DIGITS    = 4,
    parameter int N_USERS     = 2,
    parameter logic [N_USERS*N_DIGITS*DIGIT_W-1:0] PSWD_INIT = 32'h5A3C_1234,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    auth_game_ctrl_if.slave io
);
    localparam int c_CODE_W = N_DIGITS * DIGIT_W;
    localparam int c_USER_W = (N_USERS > 1) ? $clog2(N_USERS) : 1;
    localparam int c_CNT_W  = $clog2(N_DIGITS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_DIGIT = c_CNT_W'(N_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_CHECK  = 3'd2,
        S_LOGGED = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_count, w_count_nxt;
    logic                r_mismatch, w_mismatch_nxt;
    logic [c_USER_W-1:0] r_user, w_user_nxt;
    logic                w_fail_evt, w_reconfig_nxt, w_in_session;
    logic                r_logged_in, r_logged_out, r_auth_fail;
    logic                r_load_p1, r_rng_gen, r_timer_en, r_timer_reconfig;

    logic [c_USER_W-1:0] w_cur_user;
    logic [c_CNT_W-1:0]  w_cur_idx;
    logic                w_user_ok, w_digit_bad;
    logic [DIGIT_W-1:0]  w_exp_digit;

    // Nothing to build for legal parameters; keeps the lockout knobs referenced in every build.
    if (N_DIGITS < 1 || N_USERS < 1 || MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_bad_cfg
    end

`ifdef AUTH_LOCKOUT_EN
    localparam int c_FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int c_LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    logic [c_FAIL_W-1:0] r_fail_cnt, w_fail_cnt_nxt;
    logic [c_LOCK_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic                r_locked;
`endif

    // The first digit is compared against the live User_Sel; later ones use the latched slot.
    always_comb begin
        w_cur_user  = (r_state == S_IDLE) ? io.User_Sel : r_user;
        w_cur_idx   = (r_state == S_ENTRY) ? r_count : '0;
        w_user_ok   = (int'(w_cur_user) < N_USERS);
        w_exp_digit = PSWD_INIT[(w_user_ok ? int'(w_cur_user) : 0) * c_CODE_W
                                + (N_DIGITS - 1 - int'(w_cur_idx)) * DIGIT_W +: DIGIT_W];
        w_digit_bad = !w_user_ok || (io.Password != w_exp_digit);
    end

    assign w_in_session = (r_state == S_LOGGED) && !io.Logout;

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_mismatch_nxt = r_mismatch;
        w_user_nxt     = r_user;
        w_fail_evt     = 1'b0;
        w_reconfig_nxt = 1'b0;
`ifdef AUTH_LOCKOUT_EN
        w_fail_cnt_nxt = r_fail_cnt;
        w_lock_cnt_nxt = r_lock_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (io.Password_Enter) begin
                    w_user_nxt     = io.User_Sel;
                    w_mismatch_nxt = w_digit_bad;
                    w_count_nxt    = c_CNT_W'(1);
                    w_reconfig_nxt = 1'b1;
                    w_state_nxt    = (N_DIGITS == 1) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (io.DigitTime_Out) begin
                    w_fail_evt = 1'b1;
                end else if (io.Password_Enter) begin
                    w_mismatch_nxt = r_mismatch | w_digit_bad;
                    w_count_nxt    = r_count + 1'b1;
                    w_reconfig_nxt = 1'b1;
                    if (r_count == c_LAST_DIGIT) begin
                        w_state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                w_count_nxt    = '0;
                w_mismatch_nxt = 1'b0;
                if (r_mismatch) begin
                    w_fail_evt = 1'b1;
                end else begin
                    w_state_nxt = S_LOGGED;
`ifdef AUTH_LOCKOUT_EN
                    w_fail_cnt_nxt = '0;
`endif
                end
            end
            S_LOGGED: begin
                if (io.Logout) begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef AUTH_LOCKOUT_EN
            S_LOCKED: begin
                if (r_lock_cnt == c_LOCK_W'(LOCK_CYCLES - 1)) begin
                    w_state_nxt    = S_IDLE;
                    w_lock_cnt_nxt = '0;
                    w_fail_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase

        // A timeout and a bad code share the same rejection path.
        if (w_fail_evt) begin
            w_count_nxt    = '0;
            w_mismatch_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
`ifdef AUTH_LOCKOUT_EN
            if (r_fail_cnt >= c_FAIL_W'(MAX_FAIL - 1)) begin
                w_fail_cnt_nxt = c_FAIL_W'(MAX_FAIL);
                w_lock_cnt_nxt = '0;
                w_state_nxt    = S_LOCKED;
            end else begin
                w_fail_cnt_nxt = r_fail_cnt + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_count          <= '0;
            r_mismatch       <= 1'b0;
            r_user           <= '0;
            r_logged_in      <= 1'b0;
            r_logged_out     <= 1'b1;
            r_auth_fail      <= 1'b0;
            r_load_p1        <= 1'b0;
            r_rng_gen        <= 1'b0;
            r_timer_en       <= 1'b0;
            r_timer_reconfig <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_count          <= w_count_nxt;
            r_mismatch       <= w_mismatch_nxt;
            r_user           <= w_user_nxt;
            r_logged_in      <= w_in_session;
            r_logged_out     <= !w_in_session;
            r_auth_fail      <= w_fail_evt;
            r_load_p1        <= io.Load_P1_In && w_in_session;
            r_rng_gen        <= io.RNG_Gen_In && w_in_session;
            r_timer_en       <= (w_state_nxt == S_ENTRY);
            r_timer_reconfig <= w_reconfig_nxt;
        end
    end

`ifdef AUTH_LOCKOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fail_cnt <= '0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_fail_cnt <= w_fail_cnt_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= (w_state_nxt == S_LOCKED);
        end
    end
    assign io.Locked = r_locked;
`else
    assign io.Locked = 1'b0;
`endif

    assign io.Logged_In      = r_logged_in;
    assign io.Logged_Out     = r_logged_out;
    assign io.Auth_Fail      = r_auth_fail;
    assign io.Load_P1_Out    = r_load_p1;
    assign io.RNG_Gen_Out    = r_rng_gen;
    assign io.Timer_enable   = r_timer_en;
    assign io.Timer_reconfig = r_timer_reconfig;
endmodule
`default_nettype wire

// File: tb/tb_auth_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_auth_game_ctrl
// Brief    : Self-checking bench for auth_game_ctrl with randomized attempts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_auth_game_ctrl;
    localparam int          MAX_FAIL    = 3;
    localparam int          LOCK_CYCLES = 16;
    localparam logic [31:0] PSWD        = 32'h5A3C_1234;
`ifdef AUTH_LOCKOUT_EN
    localparam bit c_LOCKOUT = 1'b1;
`else
    localparam bit c_LOCKOUT = 1'b0;
`endif
    // Output vector order: Logged_In, Logged_Out, Auth_Fail, Locked, Load, RNG, T_en, T_reconf
    localparam logic [7:0] c_OUT_IDLE   = 8'b0100_0000;
    localparam logic [7:0] c_OUT_ENTRY  = 8'b0100_0011;
    localparam logic [7:0] c_OUT_LAST   = 8'b0100_0001;
    localparam logic [7:0] c_OUT_LOGGED = 8'b1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] outs;

    always #5 clk = ~clk;

    auth_game_ctrl_if #(.DIGIT_W(4), .USER_W(1)) bus ();

    auth_game_ctrl #(
        .DIGIT_W(4), .N_DIGITS(4), .N_USERS(2), .PSWD_INIT(PSWD),
        .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    assign outs = {bus.Logged_In, bus.Logged_Out, bus.Auth_Fail, bus.Locked,
                   bus.Load_P1_Out, bus.RNG_Gen_Out, bus.Timer_enable, bus.Timer_reconfig};

    // Reference code digit: user u's code is a 16-bit slot, first digit in its top nibble.
    function automatic logic [3:0] ref_digit(input int u, input int i);
        logic [31:0] p;
        p = PSWD >> (u * 16 + (3 - i) * 4);
        return p[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Password_Enter = 1'b0;
        bus.Password       = '0;
        bus.User_Sel       = '0;
        bus.Logout         = 1'b0;
        bus.Load_P1_In     = 1'b0;
        bus.RNG_Gen_In     = 1'b0;
        bus.DigitTime_Out  = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d, input logic u);
        bus.Password_Enter = 1'b1;
        bus.Password       = d;
        bus.User_Sel       = u;
        tick();
        bus.Password_Enter = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        n_vec++;
        if (outs !== c_OUT_IDLE) begin n_err++; $display("FAIL reset_outputs got=%b exp=%b", outs, c_OUT_IDLE); end
        rst = 1'b0;
        tick();
        n_vec++;
        if (outs !== c_OUT_IDLE) begin n_err++; $display("FAIL reset_release got=%b exp=%b", outs, c_OUT_IDLE); end
    endtask

    task automatic test_login_user0();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            send_digit(ref_digit(0, i), 1'b0);
            exp = (i == 3) ? c_OUT_LAST : c_OUT_ENTRY;
            n_vec++;
            if (outs !== exp) begin n_err++; $display("FAIL login0_digit%0d got=%b exp=%b", i, outs, exp); end
        end
        tick();
        n_vec++;
        if (outs !== c_OUT_IDLE) begin n_err++; $display("FAIL login0_edge1 got=%b exp=%b", outs, c_OUT_IDLE); end
        tick();
        n_vec++;
        if (outs !== c_OUT_LOGGED) begin n_err++; $display("FAIL login0_edge2 got=%b exp=%b", outs, c_OUT_LOGGED); end
        bus.Logout = 1'b1;
        tick();
        bus.Logout = 1'b0;
        n_vec++;
        if (outs !== c_OUT_IDLE) begin n_err++; $display("FAIL logout0 got=%b exp=%b", outs, c_OUT_IDLE); end
    endtask

    task automatic test_user1_load();
        for (int i = 0; i < 4; i++)
            send_digit(ref_digit(1, i), (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        repeat (2) tick();
        n_vec++;
        if (outs !== c_OUT_LOGGED) begin n_err++; $display("FAIL login1 got=%b exp=%b", outs, c_OUT_LOGGED); end
        bus.Load_P1_In = 1'b1;
        tick();
        bus.Load_P1_In = 1'b0;
        n_vec++;
        if (outs !== 8'b1000_1000) begin n_err++; $display("FAIL load_pulse got=%b exp=10001000", outs); end
        bus.RNG_Gen_In = 1'b1;
        tick();
        bus.RNG_Gen_In = 1'b0;
        n_vec++;
        if (outs !== 8'b1000_0100) begin n_err++; $display("FAIL rng_pulse got=%b exp=10000100", outs); end
        for (int i = 0; i < 2; i++) begin
            send_digit(4'h1, 1'b0);
            n_vec++;
            if (outs !== c_OUT_LOGGED) begin n_err++; $display("FAIL logged_ignore%0d got=%b exp=%b", i, outs, c_OUT_LOGGED); end
        end
        bus.Logout = 1'b1;
        bus.Load_P1_In = 1'b1;
        bus.RNG_Gen_In = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if (outs !== c_OUT_IDLE) begin n_err++; $display("FAIL logout_drop got=%b exp=%b", outs, c_OUT_IDLE); end
    endtask

    task automatic test_wrong_code();
        int pulses = 0;
        logic saw_login = 1'b0;
        send_digit(4'h1, 1'b0); send_digit(4'h2, 1'b0);
        send_digit(4'h3, 1'b0); send_digit(4'h5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            pulses += int'(bus.Auth_Fail);
            saw_login |= bus.Logged_In;
        end
        n_vec++;
        if (pulses != 1 || saw_login !== 1'b0) begin
            n_err++; $display("FAIL wrong_code pulses=%0d login=%b exp pulses=1 login=0", pulses, saw_login);
        end
        n_vec++;
        if (outs !== c_OUT_IDLE) begin n_err++; $display("FAIL wrong_code_idle got=%b exp=%b", outs, c_OUT_IDLE); end
    endtask

    task automatic test_timeout();
        int pulses;
        logic saw_login = 1'b0;
        send_digit(4'h1, 1'b0); send_digit(4'h2, 1'b0); send_digit(4'h3, 1'b0);
        bus.Password_Enter = 1'b1;
        bus.Password       = 4'h4;
        bus.DigitTime_Out  = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if (outs[1:0] !== 2'b00) begin n_err++; $display("FAIL timeout_timer got=%b exp=00", outs[1:0]); end
        pulses = int'(bus.Auth_Fail);
        for (int k = 0; k < 4; k++) begin
            tick();
            pulses += int'(bus.Auth_Fail);
            saw_login |= bus.Logged_In;
        end
        n_vec++;
        if (pulses != 1 || saw_login !== 1'b0) begin
            n_err++; $display("FAIL timeout pulses=%0d login=%b exp pulses=1 login=0", pulses, saw_login);
        end
    endtask

    task automatic test_gating();
        bus.Load_P1_In = 1'b1;
        bus.RNG_Gen_In = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (outs !== c_OUT_IDLE) begin n_err++; $display("FAIL gate_idle%0d got=%b exp=%b", k, outs, c_OUT_IDLE); end
        end
        for (int i = 0; i < 4; i++) send_digit(ref_digit(0, i), 1'b0);
        tick();
        n_vec++;
        if (outs[3:2] !== 2'b00) begin n_err++; $display("FAIL gate_entry got=%b exp=00", outs[3:2]); end
        tick();
        n_vec++;
        if (outs !== 8'b1000_1100) begin n_err++; $display("FAIL gate_open got=%b exp=10001100", outs); end
        idle_inputs();
        bus.Logout = 1'b1;
        tick();
        bus.Logout = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_digit(4'h1, 1'b0);
        send_digit(4'h2, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (outs !== c_OUT_IDLE) begin n_err++; $display("FAIL async_reset got=%b exp=%b", outs, c_OUT_IDLE); end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send_digit(ref_digit(0, i), 1'b0);
        repeat (2) tick();
        n_vec++;
        if (outs !== c_OUT_LOGGED) begin n_err++; $display("FAIL relogin got=%b exp=%b", outs, c_OUT_LOGGED); end
        bus.Logout = 1'b1;
        tick();
        bus.Logout = 1'b0;
    endtask

    task automatic test_random();
        int streak = 0;
        for (int n = 0; n < 40; n++) begin
            int         u, len;
            logic       pass, lock_exp;
            logic [3:0] d [4];
            u    = int'($urandom_range(0, 1));
            pass = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 4; i++) d[i] = ref_digit(u, i);
            if (!pass) begin
                int p;
                p = int'($urandom_range(0, 3));
                d[p] = d[p] ^ 4'($urandom_range(1, 15));
            end
            for (int i = 0; i < 4; i++) begin
                if (i > 0) begin
                    repeat ($urandom_range(0, 2)) begin
                        bus.Load_P1_In = 1'($urandom_range(0, 1));
                        tick();
                    end
                end
                bus.RNG_Gen_In = 1'($urandom_range(0, 1));
                send_digit(d[i], (i == 0) ? 1'(u) : 1'($urandom_range(0, 1)));
            end
            idle_inputs();
            n_vec++;
            if (outs[3:2] !== 2'b00) begin n_err++; $display("FAIL rnd%0d_gate got=%b exp=00", n, outs[3:2]); end
            streak   = pass ? 0 : streak + 1;
            lock_exp = c_LOCKOUT && (streak >= MAX_FAIL);
            tick();
            n_vec++;
            if ({bus.Auth_Fail, bus.Locked} !== {~pass, lock_exp}) begin
                n_err++; $display("FAIL rnd%0d_result fail/lock got=%b%b exp=%b%b", n, bus.Auth_Fail, bus.Locked, ~pass, lock_exp);
            end
            tick();
            n_vec++;
            if (bus.Logged_In !== pass) begin n_err++; $display("FAIL rnd%0d_login got=%b exp=%b", n, bus.Logged_In, pass); end
            if (pass) begin
                bus.Logout = 1'b1;
                tick();
                bus.Logout = 1'b0;
                n_vec++;
                if (outs !== c_OUT_IDLE) begin n_err++; $display("FAIL rnd%0d_logout got=%b exp=%b", n, outs, c_OUT_IDLE); end
            end
            if (lock_exp) begin
                len = 1 + int'(bus.Locked);
                for (int w = 0; w < 40 && bus.Locked; w++) begin
                    tick();
                    len += int'(bus.Locked);
                end
                n_vec++;
                if (len != LOCK_CYCLES) begin n_err++; $display("FAIL rnd%0d_lock_len got=%0d exp=%0d", n, len, LOCK_CYCLES); end
                streak = 0;
            end
        end
    endtask

    task automatic test_lockout();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int a = 0; a < MAX_FAIL; a++) begin
            send_digit(4'h1, 1'b0); send_digit(4'h2, 1'b0);
            send_digit(4'h3, 1'b0); send_digit(4'h5, 1'b0);
            tick();
            n_vec++;
            if ({bus.Auth_Fail, bus.Locked} !== {1'b1, c_LOCKOUT && (a == MAX_FAIL - 1)}) begin
                n_err++; $display("FAIL lock_attempt%0d fail/lock got=%b%b", a, bus.Auth_Fail, bus.Locked);
            end
            if (a < MAX_FAIL - 1) tick();
        end
`ifdef AUTH_LOCKOUT_EN
        begin
            int len = 1;
            for (int i = 0; i < 4; i++) begin
                send_digit(ref_digit(0, i), 1'b0);
                len += int'(bus.Locked);
            end
            for (int w = 0; w < 40 && bus.Locked; w++) begin
                tick();
                len += int'(bus.Locked);
            end
            n_vec++;
            if (len != LOCK_CYCLES) begin n_err++; $display("FAIL lock_len got=%0d exp=%0d", len, LOCK_CYCLES); end
            n_vec++;
            if (outs !== c_OUT_IDLE) begin n_err++; $display("FAIL lock_exit got=%b exp=%b", outs, c_OUT_IDLE); end
        end
`else
        tick();
`endif
        for (int i = 0; i < 4; i++) send_digit(ref_digit(0, i), 1'b0);
        repeat (2) tick();
        n_vec++;
        if (outs !== c_OUT_LOGGED) begin n_err++; $display("FAIL post_lock_login got=%b exp=%b", outs, c_OUT_LOGGED); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_login_user0();
        test_user1_load();
        test_wrong_code();
        test_timeout();
        test_gating();
        test_reset_mid();
        test_random();
        test_lockout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "bench did not complete");
    end
endmodule
`default_nettype wire
